// File: rtl/xpu_vpu_pc_tn_vlsu_dcq_ctrl.sv
// VLSU data-complete queue control: in-order create/release and VRF write-back.
// Define XPU_VPU_PC_TN_VLSU_DCQ_PERF_EN to build the full-stall perf counter.
module xpu_vpu_pc_tn_vlsu_dcq_ctrl (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        giu_xx_async_flush,
  input  logic        pipe_dcq_crt_req,
  output logic        dcq_pipe_crt_gnt,
  output logic [7:0]  dcq_entry_crt_vld_x,
  output logic [7:0]  dcq_entry_rls_vld_x,
  input  logic [7:0]  entry_dcq_vld,
  input  logic [7:0]  entry_dcq_wb_vld,
  input  logic        ld_dcq_data_vld,
  input  logic [2:0]  ld_dcq_data_ptr,
  output logic        dcq_vrf_wb_req,
  output logic [2:0]  dcq_vrf_wb_ptr,
  input  logic        vrf_dcq_wb_gnt,
  output logic        dcq_full,
  output logic        dcq_empty,
  output logic [3:0]  dcq_cnt,
  output logic [15:0] dcq_perf_full_stall_cnt
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] WB_REQ = 1'b1;

  logic [3:0] crt_ptr;
  logic [3:0] rls_ptr;
  logic [7:0] data_rdy;
  logic [7:0] data_set;
  logic [7:0] rdy_clr;
  logic [0:0] wb_cur;
  logic [0:0] wb_nxt;
  logic [2:0] head;
  logic       head_vld;
  logic       head_wb;
  logic       head_rdy;
  logic       flush;
  logic       live;
  logic       crt_fire;
  logic       rls_fire;

  assign flush = giu_xx_async_flush;
  // strobes and requests are quiet both in reset and in a flush cycle
  assign live  = cpurst_b & ~flush;

  assign dcq_cnt   = crt_ptr - rls_ptr;
  assign dcq_full  = (dcq_cnt == 4'd8);
  assign dcq_empty = (dcq_cnt == 4'd0);

  assign dcq_pipe_crt_gnt = ~dcq_full & ~flush;

  assign crt_fire = pipe_dcq_crt_req
                  & dcq_pipe_crt_gnt
                  & cpurst_b;

  assign head     = rls_ptr[2:0];
  assign head_vld = entry_dcq_vld[head];
  assign head_wb  = entry_dcq_wb_vld[head];
  assign head_rdy = head_vld
                  & (data_rdy[head] | ~head_wb);

  always_comb begin
    wb_nxt   = wb_cur;
    rls_fire = 1'b0;
    unique case (wb_cur)
      IDLE: begin
        if (head_rdy & ~head_wb) begin
          rls_fire = live;
        end else if (head_rdy & head_wb) begin
          wb_nxt = WB_REQ;
        end
      end
      WB_REQ: begin
        if (vrf_dcq_wb_gnt) begin
          rls_fire = live;
          wb_nxt   = IDLE;
        end
      end
      default: wb_nxt = IDLE;
    endcase
  end

  assign dcq_entry_crt_vld_x = crt_fire
                             ? (8'h01 << crt_ptr[2:0])
                             : 8'h00;
  assign dcq_entry_rls_vld_x = rls_fire
                             ? (8'h01 << head)
                             : 8'h00;

  assign dcq_vrf_wb_req = (wb_cur == WB_REQ) & live;
  assign dcq_vrf_wb_ptr = head;

  // returned data only counts for an entry that is currently live
  assign data_set = ld_dcq_data_vld
                  ? ((8'h01 << ld_dcq_data_ptr) & entry_dcq_vld)
                  : 8'h00;
  assign rdy_clr  = dcq_entry_crt_vld_x
                  | dcq_entry_rls_vld_x;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      crt_ptr <= 4'd0;
      rls_ptr <= 4'd0;
    end else if (flush) begin
      crt_ptr <= 4'd0;
      rls_ptr <= 4'd0;
    end else begin
      crt_ptr <= crt_ptr + {3'd0, crt_fire};
      rls_ptr <= rls_ptr + {3'd0, rls_fire};
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      data_rdy <= 8'h00;
    end else if (flush) begin
      data_rdy <= 8'h00;
    end else begin
      data_rdy <= (data_rdy | data_set) & ~rdy_clr;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wb_cur <= IDLE;
    end else if (flush) begin
      wb_cur <= IDLE;
    end else begin
      wb_cur <= wb_nxt;
    end
  end

`ifdef XPU_VPU_PC_TN_VLSU_DCQ_PERF_EN
  logic [15:0] perf_cnt;
  logic        perf_inc;

  assign perf_inc = pipe_dcq_crt_req
                  & dcq_full
                  & ~(&perf_cnt);

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      perf_cnt <= 16'h0000;
    end else if (flush) begin
      perf_cnt <= 16'h0000;
    end else if (perf_inc) begin
      perf_cnt <= perf_cnt + 16'h0001;
    end
  end

  assign dcq_perf_full_stall_cnt = perf_cnt;
`else
  assign dcq_perf_full_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_xpu_vpu_pc_tn_vlsu_dcq_ctrl.sv
// Directed bench for the DCQ control block with an entry model and
// an in-order release scoreboard.
module tb_xpu_vpu_pc_tn_vlsu_dcq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req;
  logic        dvld;
  logic [2:0]  dptr;
  logic        gnt_in;
  logic        wb_in;
  logic        gnt;
  logic [7:0]  crt_x;
  logic [7:0]  rls_x;
  logic [7:0]  ent_vld = 8'h00;
  logic [7:0]  ent_wb  = 8'h00;
  logic        wb_req;
  logic [2:0]  wb_ptr;
  logic        full;
  logic        empty;
  logic [3:0]  cnt;
  logic [15:0] perf;

`ifdef XPU_VPU_PC_TN_VLSU_DCQ_PERF_EN
  localparam int PERF_EXP = 10;
`else
  localparam int PERF_EXP = 0;
`endif

  int errs   = 0;
  int checks = 0;

  logic [7:0] cap_crt   = 8'h00;
  logic [7:0] cap_rls   = 8'h00;
  logic       cap_flush = 1'b0;
  logic       cap_wb    = 1'b0;
  logic       cap_rst   = 1'b0;

  logic [2:0] crt_idx = 3'd0;
  logic [2:0] rls_idx = 3'd0;
  logic [2:0] rel_q[$];
  logic [2:0] exp_idx;

  xpu_vpu_pc_tn_vlsu_dcq_ctrl dut (
    .forever_cpuclk          (clk),
    .cpurst_b                (rst_n),
    .giu_xx_async_flush      (flush),
    .pipe_dcq_crt_req        (req),
    .dcq_pipe_crt_gnt        (gnt),
    .dcq_entry_crt_vld_x     (crt_x),
    .dcq_entry_rls_vld_x     (rls_x),
    .entry_dcq_vld           (ent_vld),
    .entry_dcq_wb_vld        (ent_wb),
    .ld_dcq_data_vld         (dvld),
    .ld_dcq_data_ptr         (dptr),
    .dcq_vrf_wb_req          (wb_req),
    .dcq_vrf_wb_ptr          (wb_ptr),
    .vrf_dcq_wb_gnt          (gnt_in),
    .dcq_full                (full),
    .dcq_empty               (empty),
    .dcq_cnt                 (cnt),
    .dcq_perf_full_stall_cnt (perf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    step();
    flush = 1'b1;
    @(negedge clk);
    step();
    flush = 1'b0;
  endtask

  // entries: valid set by create strobe, cleared by release, flush or reset
  always @(posedge clk) begin
    if (!cap_rst || cap_flush) ent_vld <= 8'h00;
    else ent_vld <= (ent_vld | cap_crt) & ~cap_rls;
    for (int i = 0; i < 8; i++)
      if (cap_crt[i]) ent_wb[i] <= cap_wb;
  end

  // scoreboard: creates push their index, releases must pop in order
  always @(negedge clk) begin
    cap_crt   = crt_x;
    cap_rls   = rls_x;
    cap_flush = flush;
    cap_wb    = wb_in;
    cap_rst   = rst_n;
    if (!rst_n) begin
      rel_q.delete();
      crt_idx = 3'd0;
      rls_idx = 3'd0;
    end else begin
      chk("mon_cnt", {28'd0, cnt}, rel_q.size());
      chk("mon_wb_ptr", {29'd0, wb_ptr}, {29'd0, rls_idx});
      if (crt_x != 8'h00) begin
        chk("mon_crt_walk", {24'd0, crt_x}, 32'd1 << crt_idx);
        rel_q.push_back(crt_idx);
        crt_idx = crt_idx + 3'd1;
      end
      if (rls_x != 8'h00) begin
        if (rel_q.size() == 0) begin
          chk("mon_rls_spurious", {24'd0, rls_x}, 32'd0);
        end else begin
          exp_idx = rel_q.pop_front();
          chk("mon_rls_order", {24'd0, rls_x}, 32'd1 << exp_idx);
        end
        rls_idx = rls_idx + 3'd1;
      end
      if (flush) begin
        rel_q.delete();
        crt_idx = 3'd0;
        rls_idx = 3'd0;
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    flush  = 1'b0;
    req    = 1'b1;
    dvld   = 1'b0;
    dptr   = 3'd0;
    gnt_in = 1'b0;
    wb_in  = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_cnt", {28'd0, cnt}, 32'd0);
    chk("rst_gnt", {31'd0, gnt}, 32'd1);
    chk("rst_crt", {24'd0, crt_x}, 32'd0);
    chk("rst_rls", {24'd0, rls_x}, 32'd0);
    chk("rst_wb_req", {31'd0, wb_req}, 32'd0);
    chk("rst_wb_ptr", {29'd0, wb_ptr}, 32'd0);
    chk("rst_perf", {16'd0, perf}, 32'd0);
    step();
    rst_n = 1'b1;
    req   = 1'b0;

    // fill with write-back entries, no data
    step();
    req   = 1'b1;
    wb_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("fill_crt", {24'd0, crt_x}, 32'd1 << i);
      chk("fill_gnt", {31'd0, gnt}, 32'd1);
      step();
    end
    @(negedge clk);
    chk("full_flag", {31'd0, full}, 32'd1);
    chk("full_cnt", {28'd0, cnt}, 32'd8);
    chk("full_gnt", {31'd0, gnt}, 32'd0);
    chk("full_crt", {24'd0, crt_x}, 32'd0);
    repeat (9) step();
    step();
    req = 1'b0;
    @(negedge clk);
    chk("perf_stall", {16'd0, perf}, PERF_EXP);

    step();
    flush = 1'b1;
    req   = 1'b1;
    @(negedge clk);
    chk("flush_gnt", {31'd0, gnt}, 32'd0);
    chk("flush_crt", {24'd0, crt_x}, 32'd0);
    step();
    flush = 1'b0;
    req   = 1'b0;
    @(negedge clk);
    chk("postflush_empty", {31'd0, empty}, 32'd1);
    chk("postflush_perf", {16'd0, perf}, 32'd0);
    chk("postflush_gnt", {31'd0, gnt}, 32'd1);

    // single write-back entry with delayed grant
    step();
    req   = 1'b1;
    wb_in = 1'b1;
    @(negedge clk);
    chk("wb_crt", {24'd0, crt_x}, 32'h01);
    step();
    req  = 1'b0;
    dvld = 1'b1;
    dptr = 3'd0;
    @(negedge clk);
    chk("wb_req_n0", {31'd0, wb_req}, 32'd0);
    step();
    dvld = 1'b0;
    @(negedge clk);
    chk("wb_req_n1", {31'd0, wb_req}, 32'd0);
    step();
    @(negedge clk);
    chk("wb_req_n2", {31'd0, wb_req}, 32'd1);
    chk("wb_ptr_n2", {29'd0, wb_ptr}, 32'd0);
    chk("wb_rls_n2", {24'd0, rls_x}, 32'd0);
    repeat (2) begin
      step();
      @(negedge clk);
      chk("wb_req_hold", {31'd0, wb_req}, 32'd1);
      chk("wb_rls_hold", {24'd0, rls_x}, 32'd0);
    end
    step();
    gnt_in = 1'b1;
    @(negedge clk);
    chk("wb_rls_gnt", {24'd0, rls_x}, 32'h01);
    step();
    gnt_in = 1'b0;
    @(negedge clk);
    chk("wb_empty", {31'd0, empty}, 32'd1);
    chk("wb_req_off", {31'd0, wb_req}, 32'd0);

    // no-wb head releases at once, wb entry follows via handshake
    do_flush();
    req   = 1'b1;
    wb_in = 1'b0;
    @(negedge clk);
    chk("nowb_crt0", {24'd0, crt_x}, 32'h01);
    chk("nowb_rls_c0", {24'd0, rls_x}, 32'd0);
    step();
    wb_in = 1'b1;
    @(negedge clk);
    chk("nowb_crt1", {24'd0, crt_x}, 32'h02);
    chk("nowb_rls0", {24'd0, rls_x}, 32'h01);
    step();
    req  = 1'b0;
    dvld = 1'b1;
    dptr = 3'd1;
    @(negedge clk);
    chk("nowb_cnt", {28'd0, cnt}, 32'd1);
    chk("nowb_req_a", {31'd0, wb_req}, 32'd0);
    step();
    dvld = 1'b0;
    @(negedge clk);
    chk("nowb_req_b", {31'd0, wb_req}, 32'd0);
    chk("nowb_rls_b", {24'd0, rls_x}, 32'd0);
    step();
    gnt_in = 1'b1;
    @(negedge clk);
    chk("nowb_req1", {31'd0, wb_req}, 32'd1);
    chk("nowb_ptr1", {29'd0, wb_ptr}, 32'd1);
    chk("nowb_rls1", {24'd0, rls_x}, 32'h02);
    step();
    gnt_in = 1'b0;
    @(negedge clk);
    chk("nowb_empty", {31'd0, empty}, 32'd1);

    // 20 no-wb entries through the queue to wrap both pointers
    do_flush();
    req   = 1'b1;
    wb_in = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("wrap_crt", {24'd0, crt_x}, 32'd1 << (i % 8));
      step();
    end
    @(negedge clk);
    chk("wrap_next", {24'd0, crt_x}, 32'h10);
    step();
    req = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("wrap_empty", {31'd0, empty}, 32'd1);

    // flush while a write-back request is pending
    do_flush();
    req   = 1'b1;
    wb_in = 1'b1;
    repeat (5) begin
      @(negedge clk);
      step();
    end
    req  = 1'b0;
    dvld = 1'b1;
    dptr = 3'd0;
    @(negedge clk);
    step();
    dvld = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("fl_wb_req", {31'd0, wb_req}, 32'd1);
    chk("fl_cnt5", {28'd0, cnt}, 32'd5);
    step();
    flush  = 1'b1;
    gnt_in = 1'b1;
    req    = 1'b1;
    @(negedge clk);
    chk("fl_req_drop", {31'd0, wb_req}, 32'd0);
    chk("fl_rls", {24'd0, rls_x}, 32'd0);
    chk("fl_crt", {24'd0, crt_x}, 32'd0);
    step();
    flush  = 1'b0;
    gnt_in = 1'b0;
    req    = 1'b0;
    dvld   = 1'b1;
    dptr   = 3'd0;
    @(negedge clk);
    chk("fl_cnt0", {28'd0, cnt}, 32'd0);
    chk("fl_idle", {31'd0, wb_req}, 32'd0);
    step();
    dvld = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("fl_ign_req", {31'd0, wb_req}, 32'd0);
      chk("fl_ign_rls", {24'd0, rls_x}, 32'd0);
      step();
    end

    // reset lands on a pending write-back
    req   = 1'b1;
    wb_in = 1'b1;
    @(negedge clk);
    step();
    req  = 1'b0;
    dvld = 1'b1;
    dptr = 3'd0;
    @(negedge clk);
    step();
    dvld = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("rt_wb_req", {31'd0, wb_req}, 32'd1);
    step();
    rst_n  = 1'b0;
    gnt_in = 1'b1;
    @(negedge clk);
    chk("rt_rls", {24'd0, rls_x}, 32'd0);
    chk("rt_req", {31'd0, wb_req}, 32'd0);
    step();
    gnt_in = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    chk("rt_empty", {31'd0, empty}, 32'd1);
    chk("rt_req_off", {31'd0, wb_req}, 32'd0);
    chk("rt_cnt", {28'd0, cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
